serial_sub_ctrl: RTL and testbench

- Bit-serial subtraction controller: computes D = A - B - borrow_in on W-bit operands using one shared 1-bit full-subtractor cell, stepping LSB-first one bit per clock.
- Registered borrow feeds back between steps.
- Sits between a requester issuing subtract jobs and a consumer of results, with valid/ready handshakes on both sides.
- Sequences the existing single-bit subtractor datapath over multi-bit words.

---
 rtl/serial_sub_pkg.sv | 15 +
 rtl/full_sub_cell.sv | 13 +
 rtl/serial_sub_ctrl.sv | 127 ++++++++++++
 tb/tb_serial_sub_ctrl.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the bit-serial subtraction controller.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Bit-index counter width; a 1-bit operand still needs a 1-bit counter.
    function automatic int cw_of(input int w);
        return (w <= 1) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/full_sub_cell.sv
// Combinational 1-bit full subtractor: d = a - b - bin, bout is the borrow out.
module full_sub_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial W-bit subtractor: one full_sub_cell stepped LSB-first, valid/ready on both sides.
// Optional SERIAL_SUB_OVF_EN adds a registered signed-overflow output (ovf).
module serial_sub_ctrl
    import serial_sub_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_valid,
    output logic         start_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         borrow_in,
    output logic         done_valid,
    input  logic         done_ready,
    output logic [W-1:0] diff,
    output logic         borrow_out,
`ifdef SERIAL_SUB_OVF_EN
    output logic         ovf,
`endif
    output logic         busy
);

    localparam int CW = cw_of(W);

    state_e        state_q, state_d;
    logic [W-1:0]  sa_q, sa_d;
    logic [W-1:0]  sb_q, sb_d;
    logic [W-1:0]  diff_q, diff_d;
    logic [CW-1:0] idx_q, idx_d;
    logic          br_q, br_d;
    logic          bout_q, bout_d;
    logic          cell_d, cell_bout;
`ifdef SERIAL_SUB_OVF_EN
    logic          ovf_q, ovf_d;
`endif

    full_sub_cell u_cell (
        .a    (sa_q[0]),
        .b    (sb_q[0]),
        .bin  (br_q),
        .d    (cell_d),
        .bout (cell_bout)
    );

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        diff_d  = diff_q;
        idx_d   = idx_q;
        br_d    = br_q;
        bout_d  = bout_q;
`ifdef SERIAL_SUB_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (start_valid) begin
                    state_d = RUN;
                    sa_d    = a;
                    sb_d    = b;
                    br_d    = borrow_in;
                    idx_d   = '0;
                    diff_d  = '0;
                end
            end
            RUN: begin
                // Written as shift-and-or so the W=1 case needs no special slice.
                diff_d = (diff_q >> 1) | (W'(cell_d) << (W - 1));
                sa_d   = sa_q >> 1;
                sb_d   = sb_q >> 1;
                br_d   = cell_bout;
                idx_d  = idx_q + CW'(1);
                if (idx_q == CW'(W - 1)) begin
                    state_d = DONE;
                    bout_d  = cell_bout;
`ifdef SERIAL_SUB_OVF_EN
                    // br_q is the borrow entering the MSB on this last step.
                    ovf_d   = br_q ^ cell_bout;
`endif
                end
            end
            DONE: begin
                if (done_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            diff_q  <= '0;
            idx_q   <= '0;
            br_q    <= 1'b0;
            bout_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            diff_q  <= diff_d;
            idx_q   <= idx_d;
            br_q    <= br_d;
            bout_q  <= bout_d;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign start_ready = (state_q == IDLE);
    assign done_valid  = (state_q == DONE);
    assign busy        = (state_q != IDLE);
    assign diff        = diff_q;
    assign borrow_out  = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf         = ovf_q;
`endif

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Bench for serial_sub_ctrl at W=1/8/13 plus standalone full_sub_cell; arithmetic reference model.
module tb_serial_sub_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [2:0]        sv, dr, bn;
    logic [2:0][63:0]  ai, bi;
    wire  [2:0]        sr, dv, bo, bz;
    wire  [2:0][63:0]  dq;
`ifdef SERIAL_SUB_OVF_EN
    wire  [2:0]        ov;
`endif

    int n_chk = 0;
    int n_bad = 0;

    function automatic int wof(input int k);
        return (k == 0) ? 1 : (k == 1) ? 8 : 13;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int WG = (g == 0) ? 1 : (g == 1) ? 8 : 13;
        wire [WG-1:0] d_w;
        assign dq[g] = 64'(d_w);
        serial_sub_ctrl #(.W(WG)) u_dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .start_valid (sv[g]),
            .start_ready (sr[g]),
            .a           (ai[g][WG-1:0]),
            .b           (bi[g][WG-1:0]),
            .borrow_in   (bn[g]),
            .done_valid  (dv[g]),
            .done_ready  (dr[g]),
            .diff        (d_w),
            .borrow_out  (bo[g]),
`ifdef SERIAL_SUB_OVF_EN
            .ovf         (ov[g]),
`endif
            .busy        (bz[g])
        );
    end

    logic fa, fb, fbi;
    wire  fd, fbo;
    full_sub_cell u_cell (.a(fa), .b(fb), .bin(fbi), .d(fd), .bout(fbo));

    task automatic chk(input string tag, input longint unsigned got, input longint unsigned exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_rst(input int k);
        chk("rst_sr", sr[k], 1);
        chk("rst_dv", dv[k], 0);
        chk("rst_busy", bz[k], 0);
        chk("rst_diff", dq[k], 0);
        chk("rst_bout", bo[k], 0);
`ifdef SERIAL_SUB_OVF_EN
        chk("rst_ovf", ov[k], 0);
`endif
    endtask

    // Runs one job on instance k; hold = extra DONE cycles with done_ready low,
    // poke = also pulse start_valid during those cycles.
    task automatic job(input int k, input longint unsigned av_i, input longint unsigned bv_i,
                       input bit bin, input int hold, input bit poke);
        int w;
        int n;
        longint unsigned m, av, bv, ed;
        longint sa, sb, r, lim;
        bit eb;
        bit eo;
        w   = wof(k);
        m   = (64'd1 << w) - 1;
        av  = av_i & m;
        bv  = bv_i & m;
        ed  = (av - bv - 64'(bin)) & m;
        eb  = (av < bv + 64'(bin));
        lim = longint'(64'd1 << (w - 1));
        sa  = (av >= 64'(lim)) ? longint'(av) - 2 * lim : longint'(av);
        sb  = (bv >= 64'(lim)) ? longint'(bv) - 2 * lim : longint'(bv);
        r   = sa - sb - longint'(bin);
        eo  = (r < -lim) || (r > lim - 1);

        n = 0;
        while (!sr[k] && n < 50) begin
            @(posedge clk); @(negedge clk); n++;
        end
        chk("idle", sr[k], 1);
        ai[k] = av; bi[k] = bv; bn[k] = bin; sv[k] = 1'b1; dr[k] = 1'($urandom_range(0, 1));
        @(posedge clk); @(negedge clk);
        sv[k] = 1'b0;
        ai[k] = {$urandom, $urandom}; bi[k] = {$urandom, $urandom}; bn[k] = 1'($urandom);
        chk("run_busy", bz[k], 1);
        chk("run_sr", sr[k], 0);
        n = 0;
        while (!dv[k] && n < w + 4) begin
            dr[k] = 1'($urandom_range(0, 1));
            @(posedge clk); @(negedge clk); n++;
        end
        chk("latency", n, w);
        for (int h = 0; h < hold; h++) begin
            dr[k] = 1'b0;
            sv[k] = poke;
            chk("hold_dv", dv[k], 1);
            chk("hold_diff", dq[k], ed);
            chk("hold_bout", bo[k], eb);
            chk("hold_sr", sr[k], 0);
            @(posedge clk); @(negedge clk);
        end
        sv[k] = 1'b0;
        chk("dv", dv[k], 1);
        chk("diff", dq[k], ed);
        chk("bout", bo[k], eb);
`ifdef SERIAL_SUB_OVF_EN
        chk("ovf", ov[k], eo);
`endif
        dr[k] = 1'b1;
        @(posedge clk); @(negedge clk);
        dr[k] = 1'b0;
        chk("ret_sr", sr[k], 1);
        chk("ret_dv", dv[k], 0);
        chk("keep_diff", dq[k], ed);
        chk("keep_bout", bo[k], eb);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        sv = '0; dr = '0; bn = '0; ai = '0; bi = '0;
        fa = 0; fb = 0; fbi = 0;

        for (int i = 0; i < 8; i++) begin
            {fa, fb, fbi} = i[2:0];
            #1;
            chk("cell_d", fd, (int'(fa) + int'(fb) + int'(fbi)) % 2);
            chk("cell_bout", fbo, (int'(fa) - int'(fb) - int'(fbi)) < 0);
        end

        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) chk_rst(k);
        rst_n = 1'b1;
        @(negedge clk);

        job(1, 64'h05, 64'h03, 1'b0, 0, 1'b0);
        job(1, 64'h00, 64'h01, 1'b0, 0, 1'b0);
        job(1, 64'h10, 64'h0F, 1'b1, 0, 1'b0);
        job(1, 64'h37, 64'hC2, 1'b0, 5, 1'b1);
        job(1, 64'h80, 64'h01, 1'b0, 0, 1'b0);
        job(1, 64'h05, 64'h03, 1'b0, 0, 1'b0);
        job(0, 64'h0, 64'h1, 1'b1, 1, 1'b0);

        // Reset in the middle of a run: idx has reached 3.
        ai[1] = 64'hC3; bi[1] = 64'h11; bn[1] = 1'b0; sv[1] = 1'b1;
        @(posedge clk); @(negedge clk);
        sv[1] = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_rst(1);
        repeat (2) begin
            @(negedge clk);
            chk("rst_hold_dv", dv[1], 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_dv", dv[1], 0);
        job(1, 64'hAA, 64'h55, 1'b0, 0, 1'b0);

        for (int j = 0; j < 1000; j++) begin
            job($urandom_range(0, 2), {$urandom, $urandom}, {$urandom, $urandom},
                1'($urandom), $urandom_range(0, 3), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
